// File: rtl/vec_loader_if.sv
// -----------------------------------------------------------------------------
// vec_loader_if
//
// Bundles the vector loader's command channel, memory read channel and
// vector register file write port into a single interface.
//
// Modports:
//   master - the loader's view. It accepts commands, issues memory read
//            requests, consumes read responses and produces register file
//            writes.
//   slave  - the environment's view: the command source, the memory and the
//            register file.
//
// Signals:
//   i_cmd_valid / o_cmd_ready            command handshake
//   i_cmd_vreg / i_cmd_base / i_cmd_stride
//                                        command payload
//   i_cmd_mask                           lane enable mask (only with
//                                        VEC_LOADER_MASK_EN)
//   o_mem_req_valid / i_mem_req_ready / o_mem_addr
//                                        read request channel
//   i_mem_rsp_valid / i_mem_rsp_data     in-order read responses, no
//                                        backpressure
//   o_write_enable / o_write_addr / o_write_data
//                                        register file write port
//   o_busy / o_done                      status
// -----------------------------------------------------------------------------
interface vec_loader_if #(
    parameter int VEC_SIZE        = 8,
    parameter int VEC_INDEX_WIDTH = 3,
    parameter int ADDR_WIDTH      = 32
);
    logic                            i_cmd_valid;
    logic                            o_cmd_ready;
    logic [VEC_INDEX_WIDTH-1:0]      i_cmd_vreg;
    logic [ADDR_WIDTH-1:0]           i_cmd_base;
    logic [ADDR_WIDTH-1:0]           i_cmd_stride;
`ifdef VEC_LOADER_MASK_EN
    logic [15:0]                     i_cmd_mask;
`endif
    logic                            o_mem_req_valid;
    logic                            i_mem_req_ready;
    logic [ADDR_WIDTH-1:0]           o_mem_addr;
    logic                            i_mem_rsp_valid;
    logic [VEC_SIZE-1:0]             i_mem_rsp_data;
    logic                            o_write_enable;
    logic [VEC_INDEX_WIDTH-1:0]      o_write_addr;
    logic [15:0][VEC_SIZE-1:0]       o_write_data;
    logic                            o_busy;
    logic                            o_done;

    modport master (
`ifdef VEC_LOADER_MASK_EN
        input  i_cmd_mask,
`endif
        input  i_cmd_valid,
        output o_cmd_ready,
        input  i_cmd_vreg,
        input  i_cmd_base,
        input  i_cmd_stride,
        output o_mem_req_valid,
        input  i_mem_req_ready,
        output o_mem_addr,
        input  i_mem_rsp_valid,
        input  i_mem_rsp_data,
        output o_write_enable,
        output o_write_addr,
        output o_write_data,
        output o_busy,
        output o_done
    );

    modport slave (
`ifdef VEC_LOADER_MASK_EN
        output i_cmd_mask,
`endif
        output i_cmd_valid,
        input  o_cmd_ready,
        output i_cmd_vreg,
        output i_cmd_base,
        output i_cmd_stride,
        input  o_mem_req_valid,
        output i_mem_req_ready,
        input  o_mem_addr,
        output i_mem_rsp_valid,
        output i_mem_rsp_data,
        input  o_write_enable,
        input  o_write_addr,
        input  o_write_data,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/vec_loader.sv
// -----------------------------------------------------------------------------
// vec_loader
//
// Vector load sequencer. It accepts a load command (destination register,
// base address, stride) and issues 16 lane reads at base + lane*stride over
// a valid/ready request channel. It collects the in-order responses into a
// 16-lane buffer and commits the buffer with a single-cycle register file
// write.
//
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous, active-high reset
//   bus    - vec_loader_if.master. Carries the command channel, the memory
//            request/response channels, the register file write port and
//            busy/done status.
//
// Optional feature (macro VEC_LOADER_MASK_EN):
//   When the macro is defined, the command carries a 16-bit lane mask.
//   Only lanes whose mask bit is set are requested, in ascending order.
//   Unset lanes are written as zero. When the macro is undefined, all 16
//   lanes are always loaded.
//
// All outputs come from registers or are decoded from the state register.
// No input has a combinational path to an output.
// -----------------------------------------------------------------------------
module vec_loader #(
    parameter int VEC_SIZE        = 8,
    parameter int VEC_INDEX_WIDTH = 3,
    parameter int ADDR_WIDTH      = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    vec_loader_if.master bus
);
    localparam int LANES = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [VEC_INDEX_WIDTH-1:0]     vreg;
    logic [ADDR_WIDTH-1:0]          stride;
    logic [ADDR_WIDTH-1:0]          req_addr;
    logic [LANES-1:0][VEC_SIZE-1:0] lane_buf;

    logic       cmd_fire;
    logic       req_valid;
    logic       req_fire;
    logic       rsp_fire;
    logic       run_done;
    logic [3:0] rsp_lane;

    logic cmd_ready;
    logic busy;
    logic write_enable;

    assign cmd_fire = (state == IDLE) && bus.i_cmd_valid;
    assign req_fire = req_valid && bus.i_mem_req_ready;

`ifdef VEC_LOADER_MASK_EN
    localparam logic [LANES-1:0] LANE_ONE = LANES'(1);

    logic [ADDR_WIDTH-1:0] base;
    logic [LANES-1:0]      req_pend;
    logic [LANES-1:0]      rsp_pend;
    logic [LANES-1:0]      req_pend_nxt;
    logic [LANES-1:0]      rsp_pend_nxt;

    function automatic logic [3:0] lowest_lane(input logic [LANES-1:0] m);
        logic [3:0] lane;
        lane = 4'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i]) begin
                lane = 4'(i);
            end
        end
        return lane;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] lane_addr(
        input logic [ADDR_WIDTH-1:0] b,
        input logic [ADDR_WIDTH-1:0] s,
        input logic [3:0]            lane
    );
        return b + ADDR_WIDTH'(lane) * s;
    endfunction

    // req_pend / rsp_pend hold the lanes still to be requested / answered.
    // Clearing the lowest set bit steps through the mask in ascending order.
    assign req_pend_nxt = req_pend & (req_pend - LANE_ONE);
    assign rsp_pend_nxt = rsp_pend & (rsp_pend - LANE_ONE);
    assign req_valid    = (state == RUN) && (req_pend != '0);
    assign rsp_lane     = lowest_lane(rsp_pend);
    assign rsp_fire     = (state == RUN) && bus.i_mem_rsp_valid && (rsp_pend != '0);
    // An empty mask finishes RUN on its first cycle without any requests.
    assign run_done     = (rsp_pend == '0) || (rsp_fire && (rsp_pend_nxt == '0));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            base     <= '0;
            req_pend <= '0;
            rsp_pend <= '0;
        end else if (cmd_fire) begin
            base     <= bus.i_cmd_base;
            req_pend <= bus.i_cmd_mask;
            rsp_pend <= bus.i_cmd_mask;
        end else begin
            if (req_fire) begin
                req_pend <= req_pend_nxt;
            end
            if (rsp_fire) begin
                rsp_pend <= rsp_pend_nxt;
            end
        end
    end

    // The request address is registered. On a command, or after each accepted
    // request, it is set to the address of the next enabled lane.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_addr <= '0;
        end else if (cmd_fire) begin
            req_addr <= lane_addr(bus.i_cmd_base, bus.i_cmd_stride,
                                  lowest_lane(bus.i_cmd_mask));
        end else if (req_fire) begin
            req_addr <= lane_addr(base, stride, lowest_lane(req_pend_nxt));
        end
    end
`else
    logic [4:0] req_cnt;
    logic [4:0] rsp_cnt;

    assign req_valid = (state == RUN) && (req_cnt < 5'd16);
    assign rsp_lane  = rsp_cnt[3:0];
    // Once the sixteenth response has landed, further beats are dropped.
    assign rsp_fire  = (state == RUN) && bus.i_mem_rsp_valid && (rsp_cnt < 5'd16);
    assign run_done  = (rsp_cnt == 5'd16) || (rsp_fire && (rsp_cnt == 5'd15));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_cnt <= '0;
            rsp_cnt <= '0;
        end else if (cmd_fire) begin
            req_cnt <= '0;
            rsp_cnt <= '0;
        end else begin
            if (req_fire) begin
                req_cnt <= req_cnt + 5'd1;
            end
            if (rsp_fire) begin
                rsp_cnt <= rsp_cnt + 5'd1;
            end
        end
    end

    // The address accumulates the stride after each accepted request.
    // Overflow wraps silently modulo 2^ADDR_WIDTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            req_addr <= '0;
        end else if (cmd_fire) begin
            req_addr <= bus.i_cmd_base;
        end else if (req_fire) begin
            req_addr <= req_addr + stride;
        end
    end
`endif

    // Command fields and the lane buffer, which is cleared on every new
    // command so that lanes never loaded read back as zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vreg     <= '0;
            stride   <= '0;
            lane_buf <= '0;
        end else if (cmd_fire) begin
            vreg     <= bus.i_cmd_vreg;
            stride   <= bus.i_cmd_stride;
            lane_buf <= '0;
        end else if (rsp_fire) begin
            lane_buf[rsp_lane] <= bus.i_mem_rsp_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cmd_ready    = 1'b0;
        busy         = 1'b1;
        write_enable = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (bus.i_cmd_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (run_done) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                write_enable = 1'b1;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.o_cmd_ready     = cmd_ready;
    assign bus.o_busy          = busy;
    assign bus.o_mem_req_valid = req_valid;
    assign bus.o_mem_addr      = req_addr;
    assign bus.o_write_enable  = write_enable;
    assign bus.o_done          = write_enable;
    assign bus.o_write_addr    = vreg;
    assign bus.o_write_data    = lane_buf;
endmodule

// File: tb/tb_vec_loader.sv
`timescale 1ns/1ps
module tb_vec_loader;
    localparam int VS = 8;
    localparam int VI = 3;
    localparam int AW = 32;

    typedef logic [15:0][VS-1:0] vec_t;
    typedef struct {
        logic [VI-1:0] vreg;
        vec_t          data;
        int            lat;
        int            acc_cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_loader_if #(.VEC_SIZE(VS), .VEC_INDEX_WIDTH(VI), .ADDR_WIDTH(AW)) bus ();

    vec_loader #(.VEC_SIZE(VS), .VEC_INDEX_WIDTH(VI), .ADDR_WIDTH(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_tests    = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int rdy_mode   = 0;   // 0: always ready, 1: toggle, 2: random
    int stale_cnt  = 0;
    int rsp_issued = 0;
    int req_seen   = 0;
    int wr_cnt     = 0;

    wr_t          exp_wr_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [VS-1:0] rsp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VS-1:0] mem_data(input logic [AW-1:0] a);
        return a[VS-1:0];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory: returns the low byte of each accepted address one cycle later.
    initial begin
        bus.i_mem_req_ready = 1'b0;
        bus.i_mem_rsp_valid = 1'b0;
        bus.i_mem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_q.size() > 0) begin
                bus.i_mem_rsp_valid = 1'b1;
                bus.i_mem_rsp_data  = rsp_q.pop_front();
                rsp_issued++;
            end else if (stale_cnt > 0) begin
                bus.i_mem_rsp_valid = 1'b1;
                bus.i_mem_rsp_data  = VS'($urandom);
                stale_cnt--;
            end else begin
                bus.i_mem_rsp_valid = 1'b0;
                bus.i_mem_rsp_data  = '0;
            end
            case (rdy_mode)
                0:       bus.i_mem_req_ready = 1'b1;
                1:       bus.i_mem_req_ready = ~bus.i_mem_req_ready;
                default: bus.i_mem_req_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Request monitor: address order and stability under backpressure.
    initial begin
        logic [AW-1:0] held_addr;
        bit            held;
        held = 1'b0;
        held_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("req_hold_valid", bus.o_mem_req_valid, 1'b1);
                    check("req_hold_addr", bus.o_mem_addr, held_addr);
                end
                held = 1'b0;
                if (bus.o_mem_req_valid) begin
                    if (bus.i_mem_req_ready) begin
                        check("req_expected", exp_addr_q.size() > 0, 1'b1);
                        if (exp_addr_q.size() > 0) begin
                            check("req_addr", bus.o_mem_addr, exp_addr_q.pop_front());
                        end
                        rsp_q.push_back(mem_data(bus.o_mem_addr));
                        req_seen++;
                    end else begin
                        held      = 1'b1;
                        held_addr = bus.o_mem_addr;
                    end
                end
            end
        end
    end

    // Write monitor: pops the scoreboard on every register file write.
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (bus.o_write_enable) begin
                wr_cnt++;
                check("done_with_we", bus.o_done, 1'b1);
                check("cmd_ready_in_write", bus.o_cmd_ready, 1'b0);
                check("write_expected", exp_wr_q.size() > 0, 1'b1);
                if (exp_wr_q.size() > 0) begin
                    w = exp_wr_q.pop_front();
                    check("wr_addr", bus.o_write_addr, w.vreg);
                    check("wr_data", bus.o_write_data, w.data);
                    if (w.lat >= 0) begin
                        check("wr_latency", cyc - w.acc_cyc, w.lat);
                    end
                end
            end else if (bus.o_done) begin
                check("done_without_we", bus.o_done, 1'b0);
            end
        end
    end

    task automatic send_cmd(input logic [VI-1:0] vreg, input logic [AW-1:0] base,
                            input logic [AW-1:0] stride, input logic [15:0] mask,
                            input int lat, input bit keep, output int acc);
        logic [15:0]   m;
        wr_t           w;
        logic [AW-1:0] a;
        int            n;
        bit            ok;
        n  = 0;
        ok = 1'b0;
        bus.i_cmd_valid  = 1'b1;
        bus.i_cmd_vreg   = vreg;
        bus.i_cmd_base   = base;
        bus.i_cmd_stride = stride;
`ifdef VEC_LOADER_MASK_EN
        bus.i_cmd_mask = mask;
        m = mask;
`else
        // all lanes load when the mask feature is absent
        m = mask | 16'hFFFF;
`endif
        acc = -1;
        while (!ok && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.o_cmd_ready) ok = 1'b1;
        end
        check("cmd_accepted", ok, 1'b1);
        if (ok) begin
            acc       = cyc;
            w.vreg    = vreg;
            w.data    = '0;
            w.lat     = lat;
            w.acc_cyc = cyc;
            for (int k = 0; k < 16; k++) begin
                if (m[k]) begin
                    a = base + AW'(k) * stride;
                    exp_addr_q.push_back(a);
                    w.data[k] = mem_data(a);
                end
            end
            exp_wr_q.push_back(w);
        end
        @(posedge clk);
        #1;
        if (!keep) bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_wr_q.size() != 0 || bus.o_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_wr_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, bus.o_cmd_ready, 1'b1);
        check({tag, "_busy"}, bus.o_busy, 1'b0);
        check({tag, "_req_valid"}, bus.o_mem_req_valid, 1'b0);
        check({tag, "_mem_addr"}, bus.o_mem_addr, '0);
        check({tag, "_write_en"}, bus.o_write_enable, 1'b0);
        check({tag, "_write_addr"}, bus.o_write_addr, '0);
        check({tag, "_write_data"}, bus.o_write_data, '0);
        check({tag, "_done"}, bus.o_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc1, acc2, r0, n, wr_before, req_before;
        logic [15:0] rmask;
        bus.i_cmd_valid  = 1'b0;
        bus.i_cmd_vreg   = '0;
        bus.i_cmd_base   = '0;
        bus.i_cmd_stride = '0;
`ifdef VEC_LOADER_MASK_EN
        bus.i_cmd_mask = '0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic load
        rdy_mode = 0;
        @(posedge clk);
        #1;
        send_cmd(3'd5, 32'h100, 32'd4, 16'hFFFF, 18, 1'b0, acc1);
        wait_idle(100);

        // Backpressure: ready toggles every cycle
        rdy_mode   = 1;
        req_before = req_seen;
        send_cmd(3'd2, 32'h2000, 32'd1, 16'hFFFF, -1, 1'b0, acc1);
        wait_idle(200);
        check("bp_req_count", req_seen - req_before, 16);

        // Address wrap-around
        rdy_mode = 0;
        send_cmd(3'd7, 32'hFFFF_FFF8, 32'd4, 16'hFFFF, 18, 1'b0, acc1);
        wait_idle(100);

        // Reset in the middle of a load, then stale responses
        r0 = rsp_issued;
        send_cmd(3'd3, 32'h4000, 32'd8, 16'hFFFF, -1, 1'b0, acc1);
        n = 0;
        while (rsp_issued < r0 + 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_progress", rsp_issued >= r0 + 7, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_wr_q.delete();
        exp_addr_q.delete();
        rsp_q.delete();
        @(negedge clk);
        check_reset_values("rst_mid");
        @(posedge clk);
        #1;
        rst       = 1'b0;
        stale_cnt = 3;
        wr_before = wr_cnt;
        repeat (25) @(posedge clk);
        #1;
        check("no_write_after_reset", wr_cnt, wr_before);
        check("idle_after_reset", bus.o_busy, 1'b0);
        send_cmd(3'd4, 32'h80, 32'd2, 16'hFFFF, 18, 1'b0, acc1);
        wait_idle(100);

        // Back-to-back commands with valid held high
        wr_before = wr_cnt;
        send_cmd(3'd1, 32'h1000, 32'd16, 16'hFFFF, 18, 1'b1, acc1);
        send_cmd(3'd2, 32'h3000, 32'd3, 16'hFFFF, 18, 1'b0, acc2);
        check("b2b_spacing", acc2 - acc1, 19);
        wait_idle(100);
        check("b2b_writes", wr_cnt - wr_before, 2);

`ifdef VEC_LOADER_MASK_EN
        req_before = req_seen;
        send_cmd(3'd6, 32'h500, 32'd4, 16'h8001, 4, 1'b0, acc1);
        wait_idle(100);
        check("mask_req_count", req_seen - req_before, 2);
        req_before = req_seen;
        send_cmd(3'd0, 32'h600, 32'd4, 16'h0000, 2, 1'b0, acc1);
        wait_idle(100);
        check("mask0_req_count", req_seen - req_before, 0);
`endif

        // Randomized loads with random memory backpressure
        rdy_mode = 2;
        for (int t = 0; t < 20; t++) begin
            rmask = 16'($urandom);
            if (t % 5 == 0) rmask = 16'hFFFF;
            send_cmd(VI'($urandom), $urandom, $urandom_range(0, 64), rmask, -1, 1'b0, acc1);
            wait_idle(300);
        end

        check("addr_queue_empty", exp_addr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
